alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_mc_if.sv | 19 +
 rtl/alu_muldiv_iter.sv | 108 ++++++++++
 rtl/alu_mc.sv | 121 ++++++++++++
 tb/tb_alu_mc.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU function codes, FSM state type and the iterative-op predicate.
package alu_pkg;

  localparam logic [5:0] FN_ADD   = 6'b000000;
  localparam logic [5:0] FN_SUB   = 6'b000001;
  localparam logic [5:0] FN_AND   = 6'b011000;
  localparam logic [5:0] FN_OR    = 6'b011110;
  localparam logic [5:0] FN_XOR   = 6'b010110;
  localparam logic [5:0] FN_NOR   = 6'b010001;
  localparam logic [5:0] FN_PASSA = 6'b011010;
  localparam logic [5:0] FN_SLL   = 6'b100000;
  localparam logic [5:0] FN_SRL   = 6'b100001;
  localparam logic [5:0] FN_SRA   = 6'b100011;
  localparam logic [5:0] FN_EQ    = 6'b110011;
  localparam logic [5:0] FN_NEQ   = 6'b110001;
  localparam logic [5:0] FN_LT    = 6'b110101;
  localparam logic [5:0] FN_LEZ   = 6'b111101;
  localparam logic [5:0] FN_GEZ   = 6'b111001;
  localparam logic [5:0] FN_GTZ   = 6'b111111;
  localparam logic [5:0] FN_MUL   = 6'b001000;
  localparam logic [5:0] FN_MULH  = 6'b001001;
  localparam logic [5:0] FN_DIV   = 6'b001010;
  localparam logic [5:0] FN_REM   = 6'b001011;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // MUL/MULH/DIV/REM share the 0010xx prefix; the low two bits select the op.
  function automatic logic isIter(input logic [5:0] fn);
    return fn[5:2] == 4'b0010;
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/result bundle between an issuing master and the multi-cycle ALU.
interface alu_mc_if #(parameter int WIDTH = 32);
  logic             iValid;
  logic             oReady;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic [5:0]       iALUFun;
  logic             iSign;
  logic             oValid;
  logic [WIDTH-1:0] oS;
  logic             oZ;
  logic             oV;
  logic             oN;

  modport master (output iValid, iA, iB, iALUFun, iSign,
                  input  oReady, oValid, oS, oZ, oV, oN);
  modport slave  (input  iValid, iA, iB, iALUFun, iSign,
                  output oReady, oValid, oS, oZ, oV, oN);
endinterface

// File: rtl/alu_muldiv_iter.sv
// One-step-per-cycle shift-add multiplier / restoring divider on magnitudes.
// Exposes the post-final-step result combinationally so the caller can register it.
module alu_muldiv_iter #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic [1:0]       fun,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res,
  output logic             v,
  output logic             n
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, mb;
  logic [1:0]       op;
  logic             negP, negR, divZero, ovf, sgn;

  logic             aNeg, bNeg;
  logic [WIDTH-1:0] ma, mbv;
  logic [WIDTH:0]   sumM, shifted, trial;
  logic             fits;
  logic [WIDTH-1:0] nxtHi, nxtLo, qv, rv;
  logic [2*WIDTH-1:0] prod, sp;

  assign aNeg = sign & a[WIDTH-1];
  assign bNeg = sign & b[WIDTH-1];
  assign ma   = aNeg ? -a : a;
  assign mbv  = bNeg ? -b : b;

  // hi/lo hold accumulator:multiplier for MUL and remainder:dividend-shift for DIV.
  assign sumM    = {1'b0, hi} + (lo[0] ? {1'b0, mb} : '0);
  assign shifted = {hi, lo[WIDTH-1]};
  assign trial   = shifted - {1'b0, mb};
  assign fits    = ~trial[WIDTH];

  always_comb begin
    if (op[1]) begin
      nxtHi = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      nxtLo = {lo[WIDTH-2:0], fits};
    end else begin
      nxtHi = sumM[WIDTH:1];
      nxtLo = {sumM[0], lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)        cnt <= '0;
    else if (start) cnt <= '0;
    else if (run)   cnt <= cnt + 1'b1;

  always_ff @(posedge clk)
    if (start) begin
      hi      <= '0;
      lo      <= ma;
      mb      <= mbv;
      op      <= fun;
      negP    <= aNeg ^ bNeg;
      negR    <= aNeg;
      divZero <= (b == '0);
      ovf     <= sign && (a == MINV) && (&b);
      sgn     <= sign;
    end else if (run) begin
      hi <= nxtHi;
      lo <= nxtLo;
    end

  assign last = run && (cnt == CW'(WIDTH-1));
  assign prod = {nxtHi, nxtLo};
  assign sp   = negP ? -prod : prod;
  assign qv   = negP ? -nxtLo : nxtLo;
  assign rv   = negR ? -nxtHi : nxtHi;

  always_comb begin
    res = '0;
    v   = 1'b0;
    n   = 1'b0;
    case (op)
      2'b00: begin
        res = sp[WIDTH-1:0];
        v   = sgn ? (sp[2*WIDTH-1:WIDTH] != {WIDTH{sp[WIDTH-1]}}) : (|prod[2*WIDTH-1:WIDTH]);
        n   = sgn & sp[2*WIDTH-1];
      end
      2'b01: begin
        res = sp[2*WIDTH-1:WIDTH];
        n   = sgn & sp[2*WIDTH-1];
      end
      2'b10: begin
        res = divZero ? '1 : qv;
        v   = divZero | ovf;
        // MIN/-1 wraps to MIN but the true quotient is positive.
        n   = sgn & res[WIDTH-1] & ~ovf;
      end
      default: begin
        res = rv;
        v   = divZero | ovf;
        n   = sgn & rv[WIDTH-1];
      end
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops computed ahead of the result register,
// MUL/MULH/DIV/REM handed to the iterative engine while the FSM sits in BUSY.
module alu_mc import alu_pkg::*; #(parameter int WIDTH = 32) (
  input logic      iClk,
  input logic      iRst,
  alu_mc_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);

  state_t           state;
  logic             accept;
  logic [WIDTH-1:0] scRes, engRes, sReg;
  logic             scV, scN, engV, engN, engLast;
  logic             validReg, zReg, vReg, nReg;
  logic [WIDTH:0]   addU, subU, addS, subS;
  logic [SW-1:0]    shamt;

  assign accept     = bus.iValid && (state == IDLE);
  assign bus.oReady = (state == IDLE);
  assign bus.oValid = validReg;
  assign bus.oS     = sReg;
  assign bus.oZ     = zReg;
  assign bus.oV     = vReg;
  assign bus.oN     = nReg;

  assign addU  = {1'b0, bus.iA} + {1'b0, bus.iB};
  assign subU  = {1'b0, bus.iA} - {1'b0, bus.iB};
  assign addS  = {bus.iA[WIDTH-1], bus.iA} + {bus.iB[WIDTH-1], bus.iB};
  assign subS  = {bus.iA[WIDTH-1], bus.iA} - {bus.iB[WIDTH-1], bus.iB};
  assign shamt = bus.iA[SW-1:0];

  always_comb begin
    scRes = '0;
    scV   = 1'b0;
    scN   = 1'b0;
    case (bus.iALUFun)
      FN_ADD: begin
        scRes = addU[WIDTH-1:0];
        scV   = bus.iSign ? (addS[WIDTH] ^ addS[WIDTH-1]) : addU[WIDTH];
        scN   = bus.iSign & addS[WIDTH];
      end
      FN_SUB: begin
        scRes = subU[WIDTH-1:0];
        // Unsigned: borrow doubles as both overflow and "A<B" negative flag.
        scV   = bus.iSign ? (subS[WIDTH] ^ subS[WIDTH-1]) : subU[WIDTH];
        scN   = bus.iSign ? subS[WIDTH] : subU[WIDTH];
      end
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_PASSA, FN_SLL, FN_SRL, FN_SRA: begin
        case (bus.iALUFun)
          FN_AND:   scRes = bus.iA & bus.iB;
          FN_OR:    scRes = bus.iA | bus.iB;
          FN_XOR:   scRes = bus.iA ^ bus.iB;
          FN_NOR:   scRes = ~(bus.iA | bus.iB);
          FN_PASSA: scRes = bus.iA;
          FN_SLL:   scRes = bus.iB << shamt;
          FN_SRL:   scRes = bus.iB >> shamt;
          default:  scRes = $signed(bus.iB) >>> shamt;
        endcase
        scN = bus.iSign & scRes[WIDTH-1];
      end
      FN_EQ:  scRes[0] = (bus.iA == bus.iB);
      FN_NEQ: scRes[0] = (bus.iA != bus.iB);
      FN_LT:  scRes[0] = bus.iSign ? ($signed(bus.iA) < $signed(bus.iB)) : (bus.iA < bus.iB);
      FN_LEZ: scRes[0] = (bus.iSign & bus.iA[WIDTH-1]) | (bus.iA == '0);
      FN_GEZ: scRes[0] = ~(bus.iSign & bus.iA[WIDTH-1]);
      FN_GTZ: scRes[0] = ~(bus.iSign & bus.iA[WIDTH-1]) & (bus.iA != '0);
      default: ;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) uIter (
    .clk   (iClk),
    .rst   (iRst),
    .start (accept && isIter(bus.iALUFun)),
    .run   (state == BUSY),
    .fun   (bus.iALUFun[1:0]),
    .sign  (bus.iSign),
    .a     (bus.iA),
    .b     (bus.iB),
    .last  (engLast),
    .res   (engRes),
    .v     (engV),
    .n     (engN)
  );

  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      state    <= IDLE;
      validReg <= 1'b0;
      sReg     <= '0;
      zReg     <= 1'b1;
      vReg     <= 1'b0;
      nReg     <= 1'b0;
    end else begin
      validReg <= 1'b0;
      case (state)
        IDLE:
          if (bus.iValid) begin
            if (isIter(bus.iALUFun)) state <= BUSY;
            else begin
              validReg <= 1'b1;
              sReg     <= scRes;
              zReg     <= (scRes == '0);
              vReg     <= scV;
              nReg     <= scN;
            end
          end
        BUSY:
          if (engLast) begin
            state    <= IDLE;
            validReg <= 1'b1;
            sReg     <= engRes;
            zReg     <= (engRes == '0);
            vReg     <= engV;
            nReg     <= engN;
          end
        default: state <= IDLE;
      endcase
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=32) with hand-computed expectations.
module tb_alu_mc;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   lat, low, seen;

  alu_mc_if #(.WIDTH(32)) bus ();
  alu_mc #(.WIDTH(32)) dut (.iClk(clk), .iRst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.iValid  = 1'b1;
    bus.iALUFun = fn;
    bus.iA      = a;
    bus.iB      = b;
    bus.iSign   = s;
  endtask

  // Present one request for a single edge, then sample 1 time unit later.
  task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, input logic s);
    setReq(fn, a, b, s);
    @(posedge clk); #1;
    bus.iValid = 1'b0;
  endtask

  task automatic waitValid(output int l, output int lo);
    l = 0; lo = 0;
    while (!bus.oValid && l < 200) begin
      if (!bus.oReady) lo++;
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic chkRes(input string tag, input logic [31:0] s, input logic v, input logic n);
    chk({tag, ".valid"}, 64'(bus.oValid), 64'd1);
    chk({tag, ".S"}, 64'(bus.oS), 64'(s));
    chk({tag, ".Z"}, 64'(bus.oZ), 64'(s == 32'd0));
    chk({tag, ".V"}, 64'(bus.oV), 64'(v));
    chk({tag, ".N"}, 64'(bus.oN), 64'(n));
  endtask

  task automatic iter(input string tag, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [31:0] es, input logic ev, input logic en);
    issue(fn, a, b, s);
    waitValid(lat, low);
    chk({tag, ".lat"}, 64'(lat), 64'd32);
    chk({tag, ".lowReady"}, 64'(low), 64'd32);
    chk({tag, ".readyAtValid"}, 64'(bus.oReady), 64'd1);
    chkRes(tag, es, ev, en);
  endtask

  initial begin
    bus.iValid = 1'b0; bus.iA = '0; bus.iB = '0; bus.iALUFun = '0; bus.iSign = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.ready", 64'(bus.oReady), 64'd1);
    chk("rst.valid", 64'(bus.oValid), 64'd0);
    chk("rst.S", 64'(bus.oS), 64'd0);
    chk("rst.Z", 64'(bus.oZ), 64'd1);
    chk("rst.V", 64'(bus.oV), 64'd0);
    chk("rst.N", 64'(bus.oN), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(FN_ADD, 32'h7FFFFFFF, 32'd1, 1'b1);
    chkRes("addOvf", 32'h80000000, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("addOvf.drop", 64'(bus.oValid), 64'd0);
    chk("addOvf.hold", 64'(bus.oS), 64'h80000000);

    issue(FN_SUB, 32'd3, 32'd5, 1'b0);
    chkRes("subU", 32'hFFFFFFFE, 1'b1, 1'b1);
    issue(FN_SUB, 32'd3, 32'd5, 1'b1);
    chkRes("subS", 32'hFFFFFFFE, 1'b0, 1'b1);

    // Three back-to-back single-cycle ops.
    setReq(FN_AND, 32'h0000F0F0, 32'h0000FF00, 1'b0);
    @(posedge clk); #1;
    chkRes("b2b.and", 32'h0000F000, 1'b0, 1'b0);
    setReq(FN_OR, 32'h00000F00, 32'h000000F0, 1'b0);
    @(posedge clk); #1;
    chkRes("b2b.or", 32'h00000FF0, 1'b0, 1'b0);
    setReq(FN_XOR, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0);
    @(posedge clk); #1;
    chkRes("b2b.xor", 32'hFFFF0000, 1'b0, 1'b0);
    chk("b2b.ready", 64'(bus.oReady), 64'd1);
    bus.iValid = 1'b0;
    @(posedge clk); #1;
    chk("b2b.drop", 64'(bus.oValid), 64'd0);

    issue(FN_NOR, 32'd0, 32'd0, 1'b1);         chkRes("nor", 32'hFFFFFFFF, 1'b0, 1'b1);
    issue(FN_SRA, 32'd4, 32'h80000000, 1'b0);  chkRes("sra", 32'hF8000000, 1'b0, 1'b0);
    issue(FN_SRL, 32'd36, 32'h80000000, 1'b0); chkRes("srl", 32'h08000000, 1'b0, 1'b0);
    issue(FN_SLL, 32'd33, 32'd1, 1'b0);        chkRes("sll", 32'd2, 1'b0, 1'b0);
    issue(FN_LT, 32'hFFFFFFFF, 32'd1, 1'b1);   chkRes("ltS", 32'd1, 1'b0, 1'b0);
    issue(FN_LT, 32'hFFFFFFFF, 32'd1, 1'b0);   chkRes("ltU", 32'd0, 1'b0, 1'b0);
    issue(FN_GTZ, 32'd0, 32'd9, 1'b1);         chkRes("gtz0", 32'd0, 1'b0, 1'b0);
    issue(FN_LEZ, 32'h80000000, 32'd0, 1'b1);  chkRes("lezNeg", 32'd1, 1'b0, 1'b0);
    issue(FN_EQ, 32'd77, 32'd77, 1'b0);        chkRes("eq", 32'd1, 1'b0, 1'b0);
    issue(6'b111000, 32'd5, 32'd6, 1'b1);      chkRes("undef", 32'd0, 1'b0, 1'b0);

    iter("mulS",   FN_MUL,  32'hFFFFFFF9, 32'd6, 1'b1, 32'hFFFFFFD6, 1'b0, 1'b1);
    iter("mulhU",  FN_MULH, 32'hFFFFFFFF, 32'd2, 1'b0, 32'd1, 1'b0, 1'b0);
    iter("mulU",   FN_MUL,  32'hFFFFFFFF, 32'd2, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0);
    iter("divS",   FN_DIV,  32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b1);
    iter("remS",   FN_REM,  32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
    iter("div0",   FN_DIV,  32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    iter("rem0",   FN_REM,  32'd5, 32'd0, 1'b0, 32'd5, 1'b1, 1'b0);
    iter("divMin", FN_DIV,  32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b1, 1'b0);
    iter("remMin", FN_REM,  32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b1, 1'b0);

    // Reset in the 10th BUSY cycle of a divide.
    issue(FN_DIV, 32'd100, 32'd7, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    chk("abort.busy", 64'(bus.oReady), 64'd0);
    #1 rst = 1'b1;
    #1;
    chk("abort.ready", 64'(bus.oReady), 64'd1);
    chk("abort.valid", 64'(bus.oValid), 64'd0);
    chk("abort.S", 64'(bus.oS), 64'd0);
    chk("abort.Z", 64'(bus.oZ), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.oValid) seen++;
    end
    chk("abort.noValid", 64'(seen), 64'd0);

    // iValid held through BUSY with a changing iA; the held ADD lands on the oValid cycle.
    setReq(FN_DIV, 32'd100, 32'd7, 1'b0);
    @(posedge clk); #1;
    bus.iALUFun = FN_ADD;
    bus.iB = 32'd1;
    lat = 0;
    while (!bus.oValid && lat < 200) begin
      bus.iA = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    chk("held.lat", 64'(lat), 64'd32);
    chkRes("held.div", 32'd14, 1'b0, 1'b0);
    bus.iA = 32'h10;
    @(posedge clk); #1;
    chkRes("held.add", 32'h11, 1'b0, 1'b0);
    bus.iValid = 1'b0;
    @(posedge clk); #1;
    chk("held.drop", 64'(bus.oValid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
